dmux_stream_1_n: RTL

Registered, parametrised 1-to-N stream demultiplexer. It is the handshaked successor of the combinational 1-2 dmux used in the systolic BN datapath. Each input beat is routed to one output channel, or broadcast to all channels. Every output has a one-entry register with valid/ready flow control. Non-selected and idle outputs drive all-zero data, keeping the zero-fill convention of the existing dmux.

---
 rtl/dmux_pkg.sv | 17 +
 rtl/dmux_stream_1_n_if.sv | 29 ++
 rtl/dmux_out_slot.sv | 28 ++
 rtl/dmux_stream_1_n.sv | 82 ++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared defaults and helpers for the 1-to-N stream demultiplexer.
package dmux_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned NUM_OUT_DEF    = 4;
  localparam int unsigned SEL_W_DEF      = (NUM_OUT_DEF > 1) ? $clog2(NUM_OUT_DEF) : 1;
  localparam int unsigned ERR_W_DEF      = 8;

  // Pull channel idx out of a flat o_data bus built with the default widths.
  function automatic logic [DATA_WIDTH_DEF-1:0] ch_slice(
    input logic [NUM_OUT_DEF*DATA_WIDTH_DEF-1:0] flat,
    input int unsigned                           idx
  );
    return flat[idx*DATA_WIDTH_DEF +: DATA_WIDTH_DEF];
  endfunction

endpackage

// File: rtl/dmux_stream_1_n_if.sv
// Input beat and per-channel output handshake bundle of the stream demux.
interface dmux_stream_1_n_if
  import dmux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_OUT    = NUM_OUT_DEF,
  parameter int unsigned SEL_W      = SEL_W_DEF
);

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         in_data;
  logic [SEL_W-1:0]              in_sel;
  logic                          in_bcast;
  logic [NUM_OUT-1:0]            o_valid;
  logic [NUM_OUT-1:0]            o_ready;
  logic [NUM_OUT*DATA_WIDTH-1:0] o_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, o_ready,
    input  in_ready, o_valid, o_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, o_ready,
    output in_ready, o_valid, o_data
  );

endinterface

// File: rtl/dmux_out_slot.sv
// One-entry output register: load wins over drain, data reads zero when empty.
module dmux_out_slot #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  // load is only raised when the slot is free, so it may overwrite a draining beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

endmodule

// File: rtl/dmux_stream_1_n.sv
// Registered 1-to-N stream demux with unicast, atomic broadcast and illegal-select counting.
module dmux_stream_1_n
  import dmux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_OUT    = NUM_OUT_DEF,
  parameter int unsigned SEL_W      = SEL_W_DEF,
  parameter int unsigned ERR_W      = ERR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  dmux_stream_1_n_if.slave   bus,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               busy
);

  logic [NUM_OUT-1:0]            slot_free;
  logic [NUM_OUT-1:0]            sel_hit;
  logic [NUM_OUT-1:0]            load;
  logic [NUM_OUT-1:0]            slot_valid;
  logic [NUM_OUT*DATA_WIDTH-1:0] slot_data;
  logic                          sel_legal;
  logic                          accept;
  logic                          drop;

  assign slot_free = ~slot_valid | bus.o_ready;

  // One-hot decode of in_sel; an out-of-range index hits no channel
  always_comb begin
    sel_hit = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      sel_hit[i] = (bus.in_sel == SEL_W'(i));
    end
  end

  assign sel_legal = |sel_hit;

  // in_ready never looks at in_valid; illegal selects are always swallowed
  always_comb begin
    bus.in_ready = 1'b1;
    load         = '0;
    if (bus.in_bcast) begin
      bus.in_ready = &slot_free;
    end else if (sel_legal) begin
      bus.in_ready = |(sel_hit & slot_free);
    end
    accept = bus.in_valid && bus.in_ready;
    if (accept) begin
      load = bus.in_bcast ? '1 : sel_hit;
    end
  end

  assign drop = bus.in_valid && !bus.in_bcast && !sel_legal;

  // Saturating count of dropped illegal-select beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (drop && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    dmux_out_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[g]),
      .din   (bus.in_data),
      .ready (bus.o_ready[g]),
      .valid (slot_valid[g]),
      .data  (slot_data[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.o_valid = slot_valid;
  assign bus.o_data  = slot_data;
  assign busy        = |slot_valid;

endmodule
